// File: rtl/avl_master_if.sv
// Avalon-MM master adapter.
// Converts a single CPU byte/halfword/word load or store into one Avalon
// transfer. It handles lane steering, store-data replication and
// load-result extension. An optional limit on consecutive waitrequest cycles
// aborts a stalled transfer with an error.
module avl_master_if #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last stall count before the abort fires. A value of zero means the
  // limit is disabled.
  localparam logic [31:0] WAIT_LAST = (WAIT_LIMIT > 0) ? 32'(WAIT_LIMIT - 1) : 32'd0;

  state_t      state, state_nxt;

  // Request fields latched at accept; they steer the load result later.
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;
  logic [31:0] wait_cnt;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        misaligned;
  logic        wait_hit;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;

  // Right-justify the addressed lane of a load and extend it to 32 bits.
  function automatic logic [31:0] ext_load(input logic [31:0] rd,
                                           input logic [1:0]  size,
                                           input logic [1:0]  lo,
                                           input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    logic [31:0]        r;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    r = 32'd0;
    case (size)
      2'b00: begin
        s = b;
        if (sgn) r = s;
        else     r = {24'd0, b};
      end
      2'b01: begin
        s = h;
        if (sgn) r = s;
        else     r = {16'd0, h};
      end
      2'b10:   r = rd;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign cpu_ready = (state == IDLE) && !reset;
  assign accept    = cpu_req && cpu_ready;
  assign wait_hit  = (WAIT_LIMIT > 0) && (wait_cnt == WAIT_LAST);
  assign cpu_done  = (state == DONE);
  assign cpu_err   = (state == DONE) && err_q;
  assign cpu_rdata = rdata_q;

  // Lane selection, store-data replication and alignment check for the request being offered.
  always_comb begin
    be_calc    = 4'b0000;
    wd_calc    = cpu_wdata;
    misaligned = 1'b0;
    case (cpu_size)
      2'b00: begin
        be_calc = 4'b0001 << cpu_addr[1:0];
        wd_calc = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wd_calc    = {2{cpu_wdata[15:0]}};
        misaligned = cpu_addr[0];
      end
      2'b10: begin
        be_calc    = 4'b1111;
        wd_calc    = cpu_wdata;
        misaligned = (cpu_addr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = misaligned ? DONE : BUS;
      BUS:  if (!waitrequest || wait_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus strobes, latched request fields, stall counter and completion result.
  always_ff @(posedge clk) begin
    if (reset) begin
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= 32'd0;
      byteenable <= 4'd0;
      writedata  <= 32'd0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'd0;
      lo_q       <= 2'd0;
      wait_cnt   <= 32'd0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= cpu_we;
            signed_q <= cpu_signed;
            size_q   <= cpu_size;
            lo_q     <= cpu_addr[1:0];
            wait_cnt <= 32'd0;
            if (misaligned) begin
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              address    <= {cpu_addr[31:2], 2'b00};
              byteenable <= be_calc;
              writedata  <= wd_calc;
              read       <= !cpu_we;
              write      <= cpu_we;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read    <= 1'b0;
            write   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'd0 : ext_load(readdata, size_q, lo_q, signed_q);
          end else if (wait_hit) begin
            read    <= 1'b0;
            write   <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
          end else if (WAIT_LIMIT > 0) begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        default: begin
          read  <= 1'b0;
          write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avl_master_if.sv
// Self-checking bench for avl_master_if: directed vectors, random transfers, stall abort and reset abort.
module tb_avl_master_if;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  always #5 clk = ~clk;

  avl_master_if #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_signed(cpu_signed), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } res_t;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   n_xfer = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference behaviour of a single request.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] wd, input logic [31:0] rd,
                                output logic bad, output logic [3:0] be,
                                output logic [31:0] wdo, output logic [31:0] rdo);
    logic [7:0]  b;
    logic [15:0] h;
    bad = 1'b0; be = 4'b0000; wdo = wd; rdo = 32'd0;
    case (size)
      2'd0: begin
        case (addr[1:0])
          2'd0: begin be = 4'b0001; b = rd[7:0];   end
          2'd1: begin be = 4'b0010; b = rd[15:8];  end
          2'd2: begin be = 4'b0100; b = rd[23:16]; end
          default: begin be = 4'b1000; b = rd[31:24]; end
        endcase
        wdo = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        rdo = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      end
      2'd1: begin
        bad = addr[0];
        be  = addr[1] ? 4'b1100 : 4'b0011;
        h   = addr[1] ? rd[31:16] : rd[15:0];
        wdo = {wd[15:0], wd[15:0]};
        rdo = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      end
      2'd2: begin
        bad = (addr[1:0] != 2'b00);
        be  = 4'b1111;
        rdo = rd;
      end
      default: bad = 1'b1;
    endcase
    if (we) rdo = 32'd0;
  endfunction

  // Completion monitor: every cpu_done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (cpu_done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          res_t e;
          e = sb.pop_front();
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
        end
      end else begin
        chk("cpu_err_not_done", {31'd0, cpu_err}, 32'd0);
      end
    end
  end

  // One complete request, with per-cycle checks of the bus side.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] wd, input logic [31:0] rd,
                      input int nwait);
    logic        bad;
    logic [3:0]  be;
    logic [31:0] wdo, rdo;
    int          ncyc;
    res_t        e;
    model(we, addr, size, sgn, wd, rd, bad, be, wdo, rdo);
    n_xfer++;
    @(negedge clk);
    chk("ready_idle", {31'd0, cpu_ready}, 32'd1);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size;
    cpu_signed = sgn; cpu_wdata = wd; readdata = rd;
    waitrequest = (nwait > 0);
    e.err   = bad || (nwait >= WL);
    e.rdata = e.err ? 32'd0 : rdo;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = ~we; cpu_addr = ~addr; cpu_size = ~size;
    cpu_signed = ~sgn; cpu_wdata = ~wd;
    if (!bad) begin
      ncyc = (nwait >= WL) ? WL : nwait + 1;
      for (int i = 0; i < ncyc; i++) begin
        @(negedge clk);
        chk("read_strobe", {31'd0, read}, {31'd0, !we});
        chk("write_strobe", {31'd0, write}, {31'd0, we});
        chk("address", address, {addr[31:2], 2'b00});
        chk("byteenable", {28'd0, byteenable}, {28'd0, be});
        if (we) chk("writedata", writedata, wdo);
        chk("ready_busy", {31'd0, cpu_ready}, 32'd0);
        waitrequest = (i < nwait);
      end
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, cpu_done}, 32'd1);
    chk("read_off", {31'd0, read}, 32'd0);
    chk("write_off", {31'd0, write}, 32'd0);
    waitrequest = 1'b0;
    @(negedge clk);
    chk("done_single", {31'd0, cpu_done}, 32'd0);
    chk("ready_back", {31'd0, cpu_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we, sgn;
    logic [1:0]  sz;
    logic [31:0] a;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_size = 2'd0;
    cpu_signed = 1'b0; cpu_wdata = 32'd0; readdata = 32'd0; waitrequest = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_err", {31'd0, cpu_err}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, cpu_ready}, 32'd1);

    // Directed vectors.
    xfer(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 32'h0000_1003, 2'b00, 1'b1, 32'h0, 32'h80FF_1234, 0);
    xfer(1'b0, 32'h0000_1003, 2'b00, 1'b0, 32'h0, 32'h80FF_1234, 0);
    xfer(1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h0000_ABCD, 32'h1234_5678, 3);
    xfer(1'b0, 32'h0000_1001, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF, 0);
    xfer(1'b0, 32'h0000_4002, 2'b01, 1'b1, 32'h0, 32'h8001_7FFF, 1);
    xfer(1'b1, 32'h0000_5001, 2'b00, 1'b0, 32'h0000_005A, 32'h0, 2);
    xfer(1'b1, 32'h0000_5003, 2'b01, 1'b0, 32'h0000_1111, 32'h0, 0);
    xfer(1'b0, 32'h0000_6000, 2'b11, 1'b0, 32'h0, 32'h1234_5678, 0);
    xfer(1'b0, 32'h0000_7000, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 100);

    // Random transfers, mostly aligned.
    for (int k = 0; k < 16; k++) begin
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ((k % 4) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
        if (sz == 2'b11) sz = 2'b10;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      xfer(we, a, sz, sgn, $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    // Reset during the second bus cycle must abort without a completion.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3000; cpu_size = 2'b10;
    cpu_signed = 1'b0; waitrequest = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_read_bus1", {31'd0, read}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_read_low", {31'd0, read}, 32'd0);
    chk("abort_no_done", {31'd0, cpu_done}, 32'd0);
    chk("abort_ready_rst", {31'd0, cpu_ready}, 32'd0);
    reset = 1'b0;
    waitrequest = 1'b0;
    #1;
    chk("abort_ready_release", {31'd0, cpu_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", {31'd0, cpu_done}, 32'd0);
    end

    chk("sb_empty", sb.size(), 32'd0);
    chk("done_count", n_done, n_xfer);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
